// File: rtl/kuuga_mem_pkg.sv
// kuuga_mem_pkg: shared helpers for the BRAM port arbiter.
// Provides clog2, byte-lane/offset derivation and the response tag type.
package kuuga_mem_pkg;

    localparam int MAX_PORTS = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Byte lanes per data word.
    function automatic int be_of(input int dw);
        return dw / 8;
    endfunction

    // Byte-address bits dropped to form a word address.
    function automatic int off_of(input int dw);
        return clog2(dw / 8);
    endfunction

    typedef struct packed {
        logic       valid;
        logic [2:0] port;
    } rsp_tag_t;

endpackage

// File: rtl/kuuga_rr_arbiter.sv
// kuuga_rr_arbiter: round-robin one-hot grant with a registered pointer.
// Ports: clk, rst_n (async low), req_i (request vector), gnt_o (one-hot grant or zero).
module kuuga_rr_arbiter
    import kuuga_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    localparam int PW = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            cand;

    // Search starts at the pointer and wraps; the first requester wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && (j == cand) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    ptr_d    = (j == NUM_PORTS - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/kuuga_bram_port_arbiter.sv
// kuuga_bram_port_arbiter: shares one single-port BRAM among NUM_PORTS byte-addressed
// requesters with round-robin grant, registered issue and in-order tagged responses.
// Ports: req_valid/req_ready/req_addr/req_we/req_wdata (per-port requests),
//   rsp_valid/rsp_rdata (responses), mem_en/mem_we/mem_addr/mem_wdata/mem_rdata (memory).
// Optional KUUGA_ARB_STATS_EN adds stat_grants/stat_stalls saturating 32-bit counters.
module kuuga_bram_port_arbiter
    import kuuga_mem_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_PORTS-1:0]                      req_valid,
    output logic [NUM_PORTS-1:0]                      req_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]           req_addr,
    input  logic [NUM_PORTS*be_of(DATA_WIDTH)-1:0]    req_we,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]           req_wdata,
    output logic [NUM_PORTS-1:0]                      rsp_valid,
    output logic [DATA_WIDTH-1:0]                     rsp_rdata,
    output logic                                      mem_en,
    output logic [be_of(DATA_WIDTH)-1:0]              mem_we,
    output logic [ADDR_WIDTH-off_of(DATA_WIDTH)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]                     mem_wdata,
    input  logic [DATA_WIDTH-1:0]                     mem_rdata
`ifdef KUUGA_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]                   stat_grants,
    output logic [NUM_PORTS*32-1:0]                   stat_stalls
`endif
);

    localparam int BE  = be_of(DATA_WIDTH);
    localparam int OFF = off_of(DATA_WIDTH);
    localparam int WAW = ADDR_WIDTH - OFF;

    logic [NUM_PORTS-1:0]  req_act;
    logic [NUM_PORTS-1:0]  gnt;
    logic [WAW-1:0]        sel_addr;
    logic [BE-1:0]         sel_we;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [2:0]            sel_id;

    logic                  en_q,    en_d;
    logic [BE-1:0]         we_q,    we_d;
    logic [WAW-1:0]        addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    rsp_tag_t              tag_d;
    rsp_tag_t              tag_q [READ_LATENCY+1];
    rsp_tag_t              tag_out;

    // Byte offset within the word does not affect the access.
    logic                  unused_addr_lo;
    assign unused_addr_lo = ^req_addr;

    // No grant may be visible while reset is held.
    assign req_act = req_valid & {NUM_PORTS{rst_n}};

    kuuga_rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req_i(req_act),
        .gnt_o(gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_addr  = '0;
        sel_we    = '0;
        sel_wdata = '0;
        sel_id    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_addr  = req_addr[p*ADDR_WIDTH+OFF +: WAW];
                sel_we    = req_we[p*BE +: BE];
                sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_id    = 3'(p);
            end
        end
    end

    always_comb begin
        en_d    = |gnt;
        we_d    = sel_we;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        tag_d   = '{valid: |gnt, port: sel_id};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tag_q[0] <= tag_d;
            for (int i = 1; i <= READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign mem_en    = en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // The last tag stage lines up with the cycle the memory presents douta;
    // the macro's output register is the data register, gated here by the tag.
    assign tag_out = tag_q[READ_LATENCY];

    always_comb begin
        rsp_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid[p] = tag_out.valid && (tag_out.port == 3'(p));
        end
    end

    assign rsp_rdata = tag_out.valid ? mem_rdata : '0;

`ifdef KUUGA_ARB_STATS_EN
    logic [31:0] grants_q [NUM_PORTS];
    logic [31:0] grants_d [NUM_PORTS];
    logic [31:0] stalls_q [NUM_PORTS];
    logic [31:0] stalls_d [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            grants_d[p] = grants_q[p];
            stalls_d[p] = stalls_q[p];
            if (gnt[p] && (grants_q[p] != 32'hFFFF_FFFF)) begin
                grants_d[p] = grants_q[p] + 32'd1;
            end
            if (req_act[p] && !gnt[p] && (stalls_q[p] != 32'hFFFF_FFFF)) begin
                stalls_d[p] = stalls_q[p] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                grants_q[p] <= '0;
                stalls_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                grants_q[p] <= grants_d[p];
                stalls_q[p] <= stalls_d[p];
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        stat_stalls = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            stat_grants[p*32 +: 32] = grants_q[p];
            stat_stalls[p*32 +: 32] = stalls_q[p];
        end
    end
`endif

endmodule

// File: tb/tb_kuuga_bram_port_arbiter.sv
// tb_kuuga_bram_port_arbiter: directed checks on a 2-port/latency-1 instance
// plus a 4-port/latency-3 instance driven against a grant-order memory model.
module tb_kuuga_bram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance 1: 2 ports, 16-bit addr, latency 1
    logic [1:0]  v1, rdy1, rv1;
    logic [31:0] a1;
    logic [7:0]  we1;
    logic [63:0] wd1;
    logic [31:0] rd1, mwd1, mrd1;
    logic        men1;
    logic [3:0]  mwe1;
    logic [13:0] maddr1;
`ifdef KUUGA_ARB_STATS_EN
    logic [63:0] sg1, ss1;
`endif

    kuuga_bram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
        .req_we(we1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1),
        .mem_wdata(mwd1), .mem_rdata(mrd1)
`ifdef KUUGA_ARB_STATS_EN
        , .stat_grants(sg1), .stat_stalls(ss1)
`endif
    );

    logic [31:0] mem1 [16384];
    logic [31:0] dp1;
    always @(posedge clk) begin
        if (men1) begin
            dp1 <= mem1[maddr1];
            for (int b = 0; b < 4; b++)
                if (mwe1[b]) mem1[maddr1][8*b +: 8] <= mwd1[8*b +: 8];
        end
    end
    assign mrd1 = dp1;

    // ---------------- instance 2: 4 ports, 8-bit addr, latency 3
    logic [3:0]   v2, rdy2, rv2;
    logic [31:0]  a2;
    logic [15:0]  we2;
    logic [127:0] wd2;
    logic [31:0]  rd2, mwd2, mrd2;
    logic         men2;
    logic [3:0]   mwe2;
    logic [5:0]   maddr2;
`ifdef KUUGA_ARB_STATS_EN
    logic [127:0] sg2, ss2;
`endif

    kuuga_bram_port_arbiter #(
        .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v2), .req_ready(rdy2), .req_addr(a2),
        .req_we(we2), .req_wdata(wd2),
        .rsp_valid(rv2), .rsp_rdata(rd2),
        .mem_en(men2), .mem_we(mwe2), .mem_addr(maddr2),
        .mem_wdata(mwd2), .mem_rdata(mrd2)
`ifdef KUUGA_ARB_STATS_EN
        , .stat_grants(sg2), .stat_stalls(ss2)
`endif
    );

    logic [31:0] mem2 [64];
    logic [31:0] dp2 [3];
    always @(posedge clk) begin
        if (men2) begin
            dp2[0] <= mem2[maddr2];
            for (int b = 0; b < 4; b++)
                if (mwe2[b]) mem2[maddr2][8*b +: 8] <= mwd2[8*b +: 8];
        end
        dp2[1] <= dp2[0];
        dp2[2] <= dp2[1];
    end
    assign mrd2 = dp2[2];

    // model state for instance 2
    logic [31:0] sh2 [64];
    logic [63:0] q2 [4][$];
    logic [3:0]  gl, exp_g;
    int          m_ptr, n_ptr;
    int          g_cnt [4];
    int          s_cnt [4];
    logic        found;
    logic [63:0] e;

    task automatic chk_idle1(input string tag);
        chk({tag, "_rdy"},  64'(rdy1),   0);
        chk({tag, "_rv"},   64'(rv1),    0);
        chk({tag, "_rd"},   64'(rd1),    0);
        chk({tag, "_en"},   64'(men1),   0);
        chk({tag, "_we"},   64'(mwe1),   0);
        chk({tag, "_addr"}, 64'(maddr1), 0);
        chk({tag, "_wd"},   64'(mwd1),   0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem1[i] = 32'hA000_0000 + 32'(i);
        mem1[4] = 32'hDEAD_BEEF;
        mem1[2] = 32'h1122_3344;
        for (int i = 0; i < 64; i++) begin
            mem2[i] = 32'h0101_0101 * 32'(i) ^ 32'h5A00_0000;
            sh2[i]  = mem2[i];
        end
        rst_n = 1'b0;
        v1 = 2'b11; a1 = {16'h0080, 16'h0040}; we1 = '0; wd1 = '0;
        v2 = '0; a2 = '0; we2 = '0; wd2 = '0;

        // reset with traffic applied
        repeat (3) @(negedge clk);
        #1 chk_idle1("reset");

        // release, then contention on both ports
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 6) v1 = 2'b00;
            #1;
            chk("rr_rdy", 64'(rdy1), (c < 6) ? ((c % 2) ? 2 : 1) : 0);
            if (c >= 1 && c <= 6) begin
                chk("rr_en", 64'(men1), 1);
                chk("rr_addr", 64'(maddr1), ((c - 1) % 2) ? 32 : 16);
            end
            if (c >= 2) begin
                chk("rr_rv", 64'(rv1), ((c - 2) % 2) ? 2 : 1);
                chk("rr_rd", 64'(rd1), ((c - 2) % 2) ? 64'hA000_0020 : 64'hA000_0010);
            end
        end

        // single read on port 1
        @(negedge clk);
        v1 = 2'b10; a1[31:16] = 16'h0010;
        #1 chk("rd_rdy", 64'(rdy1), 2);
        @(negedge clk);
        v1 = 2'b00;
        #1;
        chk("rd_en", 64'(men1), 1);
        chk("rd_addr", 64'(maddr1), 4);
        chk("rd_we", 64'(mwe1), 0);
        chk("rd_rv0", 64'(rv1), 0);
        @(negedge clk);
        #1;
        chk("rd_rv", 64'(rv1), 2);
        chk("rd_data", 64'(rd1), 64'hDEAD_BEEF);

        // byte write, read-after-write, misaligned read
        @(negedge clk);
        v1 = 2'b01; a1[15:0] = 16'h0008; we1[3:0] = 4'b0010; wd1[31:0] = 32'h0000_AB00;
        #1 chk("bw_rdy", 64'(rdy1), 1);
        @(negedge clk);
        we1[3:0] = 4'b0000;
        #1;
        chk("bw_rdy2", 64'(rdy1), 1);
        chk("bw_en", 64'(men1), 1);
        chk("bw_we", 64'(mwe1), 64'b0010);
        chk("bw_addr", 64'(maddr1), 2);
        chk("bw_wd", 64'(mwd1), 64'h0000_AB00);
        @(negedge clk);
        a1[15:0] = 16'h000B;
        #1;
        chk("bw_rv", 64'(rv1), 1);
        chk("bw_rdfirst", 64'(rd1), 64'h1122_3344);
        chk("bw_we0", 64'(mwe1), 0);
        @(negedge clk);
        v1 = 2'b00;
        #1;
        chk("raw_rv", 64'(rv1), 1);
        chk("raw_data", 64'(rd1), 64'h1122_AB44);
        chk("mis_addr", 64'(maddr1), 2);
        @(negedge clk);
        #1;
        chk("mis_rv", 64'(rv1), 1);
        chk("mis_data", 64'(rd1), 64'h1122_AB44);

        // reset mid-flight after three grants (1, 0, 0)
        @(negedge clk);
        v1 = 2'b11; a1 = {16'h0080, 16'h0040};
        #1 chk("mf_g0", 64'(rdy1), 2);
        @(negedge clk);
        #1 chk("mf_g1", 64'(rdy1), 1);
        @(negedge clk);
        v1 = 2'b01;
        #1 chk("mf_g2", 64'(rdy1), 1);
        @(negedge clk);
        rst_n = 1'b0; v1 = 2'b00;
        #1 chk_idle1("mf_rst");
        @(negedge clk);
        #1 chk("mf_rst_rv", 64'(rv1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("mf_post_rv", 64'(rv1), 0);
            chk("mf_post_en", 64'(men1), 0);
            @(negedge clk);
        end
        v1 = 2'b11;
        #1 chk("mf_ptr0", 64'(rdy1), 1);
        @(negedge clk);
        v1 = 2'b00;
`ifdef KUUGA_ARB_STATS_EN
        #1;
        chk("st1_grants", sg1, {32'd0, 32'd1});
        chk("st1_stalls", ss1, {32'd1, 32'd0});
`endif

        // random traffic on the 4-port, latency-3 instance
        gl = '0; m_ptr = 0;
        for (int p = 0; p < 4; p++) begin g_cnt[p] = 0; s_cnt[p] = 0; end
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (rv2[p]) begin
                    if (q2[p].size() == 0) begin
                        chk("rsp_unexp", 64'(p), 64'hFF);
                    end else begin
                        e = q2[p].pop_front();
                        chk("rsp_lat", 64'(k), 64'(e[63:32]));
                        chk("rsp_data", 64'(rd2), 64'(e[31:0]));
                    end
                end
            end
            chk("rsp_1hot", 64'($countones(rv2) > 1), 0);
            for (int p = 0; p < 4; p++) begin
                if (!v2[p] || gl[p]) begin
                    v2[p] = (k < 560) && ($urandom_range(0, 9) < 6);
                    a2[p*8 +: 8] = 8'($urandom_range(0, 255));
                    we2[p*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                    wd2[p*32 +: 32] = $urandom;
                end
            end
            #1;
            exp_g = '0; found = 1'b0; n_ptr = m_ptr;
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr + i) % 4;
                if (!found && v2[c]) begin
                    found = 1'b1; exp_g[c] = 1'b1; n_ptr = (c + 1) % 4;
                end
            end
            m_ptr = n_ptr;
            chk("rr4_grant", 64'(rdy2), 64'(exp_g));
            gl = rdy2 & v2;
            for (int p = 0; p < 4; p++) begin
                if (gl[p]) begin
                    int w;
                    w = int'(a2[p*8+2 +: 6]);
                    q2[p].push_back({32'(k + 4), sh2[w]});
                    for (int b = 0; b < 4; b++)
                        if (we2[p*4+b]) sh2[w][8*b +: 8] = wd2[p*32+8*b +: 8];
                    g_cnt[p]++;
                end else if (v2[p]) begin
                    s_cnt[p]++;
                end
            end
        end
        @(negedge clk);
        #1;
        for (int p = 0; p < 4; p++) chk("q_drain", 64'(q2[p].size()), 0);
`ifdef KUUGA_ARB_STATS_EN
        for (int p = 0; p < 4; p++) begin
            chk("st2_grants", 64'(sg2[p*32 +: 32]), 64'(g_cnt[p]));
            chk("st2_stalls", 64'(ss2[p*32 +: 32]), 64'(s_cnt[p]));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
